// File: rtl/tns_decoder_33.sv
// tns_decoder_33: iterative decoder for 33-bit TNS code words.
// Rebuilds the data word one 3-bit group per cycle, from group 11 down to group 1.
`ifndef TNS_VH
`define TNS_VH
`define BLEN11  28
`define TNS01_A 4
`define TNS01_B 2
`define TNS01_C 1
`define TNS02_A 24
`define TNS02_B 12
`define TNS02_C 6
`define TNS03_A 144
`define TNS03_B 72
`define TNS03_C 36
`define TNS04_A 864
`define TNS04_B 432
`define TNS04_C 216
`define TNS05_A 5184
`define TNS05_B 2592
`define TNS05_C 1296
`define TNS06_A 31104
`define TNS06_B 15552
`define TNS06_C 7776
`define TNS07_A 186624
`define TNS07_B 93312
`define TNS07_C 46656
`define TNS08_A 1119744
`define TNS08_B 559872
`define TNS08_C 279936
`define TNS09_A 6718464
`define TNS09_B 3359232
`define TNS09_C 1679616
`define TNS10_A 40310784
`define TNS10_B 20155392
`define TNS10_C 10077696
`define TNS11_A 241864704
`define TNS11_B 120932736
`define TNS11_C 60466176
`endif

module tns_decoder_33 (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [32:0]        codein,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [`BLEN11-1:0] dataout,
    output logic               err,
    output logic               out_valid,
    input  logic               out_ready
);
    localparam int DATA_W = `BLEN11;
    localparam int ACC_W  = `BLEN11 + 2;

    typedef enum logic [1:0] {IDLE, DECODE, DONE} state_t;

    state_t           state, state_nxt;
    logic [32:0]      code_q;
    logic [3:0]       grp;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [ACC_W-1:0] w_a, w_b, w_c;
    logic [2:0]       bits;

    // Anything at or above 2^DATA_W cannot be represented in dataout.
    function automatic logic over_range(input logic [ACC_W-1:0] v);
        return |v[ACC_W-1:DATA_W];
    endfunction

    always_comb begin
        w_a  = '0;
        w_b  = '0;
        w_c  = '0;
        bits = '0;
        case (grp)
            4'd11: begin w_a = ACC_W'(`TNS11_A); w_b = ACC_W'(`TNS11_B); w_c = ACC_W'(`TNS11_C); bits = code_q[32:30]; end
            4'd10: begin w_a = ACC_W'(`TNS10_A); w_b = ACC_W'(`TNS10_B); w_c = ACC_W'(`TNS10_C); bits = code_q[29:27]; end
            4'd9:  begin w_a = ACC_W'(`TNS09_A); w_b = ACC_W'(`TNS09_B); w_c = ACC_W'(`TNS09_C); bits = code_q[26:24]; end
            4'd8:  begin w_a = ACC_W'(`TNS08_A); w_b = ACC_W'(`TNS08_B); w_c = ACC_W'(`TNS08_C); bits = code_q[23:21]; end
            4'd7:  begin w_a = ACC_W'(`TNS07_A); w_b = ACC_W'(`TNS07_B); w_c = ACC_W'(`TNS07_C); bits = code_q[20:18]; end
            4'd6:  begin w_a = ACC_W'(`TNS06_A); w_b = ACC_W'(`TNS06_B); w_c = ACC_W'(`TNS06_C); bits = code_q[17:15]; end
            4'd5:  begin w_a = ACC_W'(`TNS05_A); w_b = ACC_W'(`TNS05_B); w_c = ACC_W'(`TNS05_C); bits = code_q[14:12]; end
            4'd4:  begin w_a = ACC_W'(`TNS04_A); w_b = ACC_W'(`TNS04_B); w_c = ACC_W'(`TNS04_C); bits = code_q[11:9];  end
            4'd3:  begin w_a = ACC_W'(`TNS03_A); w_b = ACC_W'(`TNS03_B); w_c = ACC_W'(`TNS03_C); bits = code_q[8:6];   end
            4'd2:  begin w_a = ACC_W'(`TNS02_A); w_b = ACC_W'(`TNS02_B); w_c = ACC_W'(`TNS02_C); bits = code_q[5:3];   end
            // Bit 0 is the unit weight regardless of the group table.
            4'd1:  begin w_a = ACC_W'(`TNS01_A); w_b = ACC_W'(`TNS01_B); w_c = ACC_W'(1);        bits = code_q[2:0];   end
            default: ;
        endcase
    end

    assign acc_nxt = acc + (bits[2] ? w_a : '0) + (bits[1] ? w_b : '0) + (bits[0] ? w_c : '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = DECODE;
            end
            DECODE: begin
                if (grp == 4'd1) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            code_q  <= '0;
            grp     <= '0;
            acc     <= '0;
            dataout <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        code_q <= codein;
                        acc    <= '0;
                        grp    <= 4'd11;
                    end
                end
                DECODE: begin
                    acc <= acc_nxt;
                    grp <= grp - 4'd1;
                    // Results are registered once, on the way into DONE.
                    if (grp == 4'd1) begin
                        dataout <= acc_nxt[DATA_W-1:0];
                        err     <= over_range(acc_nxt);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tns_decoder_33.sv
// tb_tns_decoder_33: randomized self-checking bench for tns_decoder_33.
// Expected words come from a bit-weight table built from the TNS defines.
`ifndef TNS_VH
`define TNS_VH
`define BLEN11  28
`define TNS01_A 4
`define TNS01_B 2
`define TNS01_C 1
`define TNS02_A 24
`define TNS02_B 12
`define TNS02_C 6
`define TNS03_A 144
`define TNS03_B 72
`define TNS03_C 36
`define TNS04_A 864
`define TNS04_B 432
`define TNS04_C 216
`define TNS05_A 5184
`define TNS05_B 2592
`define TNS05_C 1296
`define TNS06_A 31104
`define TNS06_B 15552
`define TNS06_C 7776
`define TNS07_A 186624
`define TNS07_B 93312
`define TNS07_C 46656
`define TNS08_A 1119744
`define TNS08_B 559872
`define TNS08_C 279936
`define TNS09_A 6718464
`define TNS09_B 3359232
`define TNS09_C 1679616
`define TNS10_A 40310784
`define TNS10_B 20155392
`define TNS10_C 10077696
`define TNS11_A 241864704
`define TNS11_B 120932736
`define TNS11_C 60466176
`endif

module tb_tns_decoder_33;
    localparam int     DW   = `BLEN11;
    localparam longint MAXV = (longint'(1) << DW) - 1;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [32:0]       codein = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     dataout;
    logic              err;
    logic              out_valid;
    logic              out_ready = 1'b0;

    int total = 0;
    int bad = 0;
    longint w[33];

    tns_decoder_33 dut (
        .clock(clock), .reset_n(reset_n), .codein(codein), .in_valid(in_valid),
        .in_ready(in_ready), .dataout(dataout), .err(err),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clock = ~clock;

    task automatic init_weights();
        w[32] = `TNS11_A; w[31] = `TNS11_B; w[30] = `TNS11_C;
        w[29] = `TNS10_A; w[28] = `TNS10_B; w[27] = `TNS10_C;
        w[26] = `TNS09_A; w[25] = `TNS09_B; w[24] = `TNS09_C;
        w[23] = `TNS08_A; w[22] = `TNS08_B; w[21] = `TNS08_C;
        w[20] = `TNS07_A; w[19] = `TNS07_B; w[18] = `TNS07_C;
        w[17] = `TNS06_A; w[16] = `TNS06_B; w[15] = `TNS06_C;
        w[14] = `TNS05_A; w[13] = `TNS05_B; w[12] = `TNS05_C;
        w[11] = `TNS04_A; w[10] = `TNS04_B; w[9]  = `TNS04_C;
        w[8]  = `TNS03_A; w[7]  = `TNS03_B; w[6]  = `TNS03_C;
        w[5]  = `TNS02_A; w[4]  = `TNS02_B; w[3]  = `TNS02_C;
        w[2]  = `TNS01_A; w[1]  = `TNS01_B; w[0]  = 1;
    endtask

    function automatic longint ref_sum(input logic [32:0] c);
        longint s = 0;
        for (int i = 0; i < 33; i++) if (c[i]) s += w[i];
        return s;
    endfunction

    // Encoder model: greedy choice of weights, largest first.
    function automatic logic [32:0] enc(input longint v);
        logic [32:0] c = '0;
        longint r = v;
        for (int i = 32; i >= 0; i--) begin
            if (r >= w[i]) begin
                c[i] = 1'b1;
                r -= w[i];
            end
        end
        return c;
    endfunction

    function automatic logic [32:0] rnd_code();
        return {1'($urandom_range(1)), 32'($urandom)};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [32:0] c);
        codein = c;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        codein = rnd_code();
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int seen;
        int lat;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL por_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL por_out_valid: got %b want 0", out_valid); end
        total++; if (dataout !== '0) begin bad++; $display("FAIL por_dataout: got %0d want 0", dataout); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL por_err: got %b want 0", err); end
        step();
        reset_n = 1'b1;
        step();
        send(33'h1_0000_0000);
        wait_out(lat);
        consume();
        send(33'h1_FFFF_FFFF);
        repeat (4) step();
        reset_n = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid: got %b want 0", out_valid); end
        total++; if (dataout !== '0) begin bad++; $display("FAIL mid_rst_dataout: got %0d want 0", dataout); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL mid_rst_err: got %b want 0", err); end
        step();
        reset_n = 1'b1;
        seen = 0;
        repeat (20) begin
            step();
            if (out_valid) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL aborted_word_out_valid: got %0d cycles want 0", seen); end
    endtask

    task automatic test_fixed_words();
        logic [32:0] codes[4] = '{33'h0, 33'h1, 33'h1_0000_0000, 33'h8};
        longint      exps[4]  = '{0, 1, `TNS11_A, `TNS02_C};
        int lat;
        for (int k = 0; k < 4; k++) begin
            send(codes[k]);
            wait_out(lat);
            total++; if (lat != 11) begin bad++; $display("FAIL fixed_latency[%0d]: got %0d want 11", k, lat); end
            total++; if (dataout !== exps[k][DW-1:0]) begin bad++; $display("FAIL fixed_data[%0d]: got %0d want %0d", k, dataout, exps[k]); end
            total++; if (err !== 1'b0) begin bad++; $display("FAIL fixed_err[%0d]: got %b want 0", k, err); end
            consume();
        end
    endtask

    task automatic test_overflow();
        longint s;
        int lat;
        s = ref_sum(33'h1_FFFF_FFFF);
        send(33'h1_FFFF_FFFF);
        wait_out(lat);
        total++; if (dataout !== s[DW-1:0]) begin bad++; $display("FAIL ovf_data: got %0d want %0d", dataout, s % (MAXV + 1)); end
        total++; if (err !== (s > MAXV)) begin bad++; $display("FAIL ovf_err: got %b want %b", err, (s > MAXV)); end
        consume();
    endtask

    task automatic test_random_codes();
        logic [32:0] c;
        longint s;
        int lat;
        for (int k = 0; k < 200; k++) begin
            c = rnd_code();
            s = ref_sum(c);
            send(c);
            wait_out(lat);
            total++; if (dataout !== s[DW-1:0] || err !== (s > MAXV) || lat != 11)
                begin bad++; $display("FAIL rand_code %h: got %0d/%b lat %0d want %0d/%b lat 11", c, dataout, err, lat, s % (MAXV + 1), (s > MAXV)); end
            consume();
        end
    endtask

    task automatic test_round_trip();
        longint v;
        int lat;
        for (int k = 0; k < 1002; k++) begin
            if (k == 0) v = 0;
            else if (k == 1) v = MAXV;
            else v = longint'($urandom) & MAXV;
            send(enc(v));
            wait_out(lat);
            total++; if (dataout !== v[DW-1:0]) begin bad++; $display("FAIL round_trip_data: got %0d want %0d", dataout, v); end
            total++; if (err !== 1'b0) begin bad++; $display("FAIL round_trip_err for %0d: got %b want 0", v, err); end
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic [32:0] c;
        longint s;
        int lat;
        int bad_cycles;
        c = rnd_code();
        s = ref_sum(c);
        send(c);
        wait_out(lat);
        bad_cycles = 0;
        repeat (7) begin
            step();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || dataout !== s[DW-1:0] || err !== (s > MAXV))
                bad_cycles++;
        end
        total++; if (bad_cycles != 0) begin bad++; $display("FAIL backpressure_hold: got %0d unstable cycles want 0", bad_cycles); end
        consume();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin bad++; $display("FAIL backpressure_release: got out_valid %b in_ready %b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_held_input();
        logic [32:0] a, b;
        longint sa, sb;
        int busy_ready;
        int lat;
        a = rnd_code();
        b = rnd_code();
        sa = ref_sum(a);
        sb = ref_sum(b);
        send(a);
        codein = b;
        in_valid = 1'b1;
        busy_ready = 0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_ready++;
            step();
            lat++;
        end
        repeat (3) begin
            if (in_ready) busy_ready++;
            step();
        end
        total++; if (busy_ready != 0) begin bad++; $display("FAIL held_in_ready_busy: got %0d ready cycles want 0", busy_ready); end
        total++; if (dataout !== sa[DW-1:0]) begin bad++; $display("FAIL held_first_data: got %0d want %0d", dataout, sa % (MAXV + 1)); end
        consume();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL held_idle_ready: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL held_accept: got in_ready %b want 0", in_ready); end
        wait_out(lat);
        total++; if (lat != 11) begin bad++; $display("FAIL held_latency: got %0d want 11", lat); end
        total++; if (dataout !== sb[DW-1:0] || err !== (sb > MAXV))
            begin bad++; $display("FAIL held_second_data: got %0d/%b want %0d/%b", dataout, err, sb % (MAXV + 1), (sb > MAXV)); end
        consume();
    endtask

    task automatic test_back_to_back();
        longint exp_q[$];
        logic [32:0] c;
        longint e;
        int n_acc = 0;
        int n_out = 0;
        int last_t = -1;
        bit take;
        out_ready = 1'b1;
        c = rnd_code();
        exp_q.push_back(ref_sum(c));
        codein = c;
        in_valid = 1'b1;
        for (int t = 0; t < 80 && n_out < 5; t++) begin
            take = in_ready && in_valid;
            step();
            if (take) begin
                n_acc++;
                if (n_acc < 5) begin
                    c = rnd_code();
                    exp_q.push_back(ref_sum(c));
                    codein = c;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                e = exp_q.pop_front();
                total++; if (dataout !== e[DW-1:0]) begin bad++; $display("FAIL b2b_data[%0d]: got %0d want %0d", n_out, dataout, e % (MAXV + 1)); end
                if (last_t >= 0) begin
                    total++; if (t - last_t != 13) begin bad++; $display("FAIL b2b_period[%0d]: got %0d want 13", n_out, t - last_t); end
                end
                last_t = t;
                n_out++;
            end
        end
        total++; if (n_out != 5) begin bad++; $display("FAIL b2b_count: got %0d want 5", n_out); end
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
    endtask

    initial begin
        init_weights();
        #1;
        test_reset();
        test_fixed_words();
        test_overflow();
        test_random_codes();
        test_round_trip();
        test_backpressure();
        test_held_input();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
